binary_frame_loader: RTL and testbench
======================================

Name: binary_frame_loader

Overview:
Writer side of the binary image memory that the median filter top reads. Accepts a raster stream of grayscale pixels and binarizes each against a threshold. Writes each bit into the flat binary memory at generated x/y addresses, column-major with y fastest. On frame completion it raises start and holds it until the median block reports fullImageDone. The start level also steers the memory address mux: loader addresses when low, median-block addresses when high.

Parameters:
X_SIZE, 240, image width; x range 0..X_SIZE-1
Y_SIZE, 180, image height; y range 0..Y_SIZE-1
PIX_W, 8, input pixel width
ADDR_W, 8, x/y address width; must satisfy 2^ADDR_W >= max(X_SIZE, Y_SIZE)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
pixelIn  input  PIX_W  grayscale pixel
pixelValid  input  1  pixelIn valid
pixelSof  input  1  qualifies the current beat as first pixel of a frame
pixelReady  output  1  loader accepts a beat when pixelValid & pixelReady
binThreshold  input  PIX_W  binarization threshold, sampled per beat
xAddressOut  output  ADDR_W  memory x address
yAddressOut  output  ADDR_W  memory y address
binaryDataOut  output  1  bit to write
binaryMemWriteEnable  output  1  memory write strobe
start  output  1  frame ready; level, held until fullImageDone
fullImageDone  input  1  median block finished the frame
frameError  output  1  one-cycle pulse: SOF arrived mid-frame
framesLoaded  output  16  count of frames handed off, wraps at 2^16

Behaviour:
- Reset (async) values: all outputs 0; state IDLE; x/y counters 0.
- pixelReady is registered. It is 1 in IDLE and LOAD and 0 in FLUSH and BUSY. After reset it rises on the first clock edge.
- Accepted beat: pixelValid & pixelReady at a rising edge.
- Write latency is 1 cycle. On the edge after acceptance:
  - binaryMemWriteEnable = 1;
  - xAddressOut/yAddressOut = the counter value at acceptance;
  - binaryDataOut = (pixelIn >= binThreshold), an unsigned compare where equality gives 1.
- With no accepted beat, binaryMemWriteEnable = 0 and the address/data outputs hold.
- Counter order:
  - y increments per accepted write beat;
  - at y = Y_SIZE-1, y wraps to 0 and x increments;
  - the frame ends at (X_SIZE-1, Y_SIZE-1).
- States:
  - IDLE: non-SOF beats are accepted and dropped (no write). An SOF beat is written at (0,0); the counter goes to (0,1); go to LOAD.
  - LOAD: every accepted beat is written.
    - An SOF beat in LOAD pulses frameError, is written at (0,0), and restarts the counter.
    - Acceptance of the final pixel goes to FLUSH; pixelReady drops on that same edge.
  - FLUSH: one cycle, during which the last write strobe is on the bus. Then go to BUSY with start = 1. Start therefore rises 2 edges after the final acceptance, and never overlaps a write strobe.
  - BUSY: start held 1; no beats accepted.
    - When fullImageDone is sampled 1: start goes 0, framesLoaded increments, state goes to IDLE, and pixelReady goes 1 on the same edge.
- fullImageDone outside BUSY is ignored.
- SOF on a beat that is not accepted has no effect.
- Gaps in pixelValid stall the counters without side effects. Any gap length is legal.
- Reset mid-frame or mid-BUSY:
  - the partial frame is abandoned;
  - start drops immediately (asynchronously);
  - framesLoaded clears.
- Writes per completed frame: exactly X_SIZE*Y_SIZE (43200 at defaults), with each address written exactly once unless an SOF restart occurs.

Test Plan:
- Continuous frame: 43200 beats, SOF on the first, binThreshold = 128, random pixels.
  - Required: 43200 strobes, first at (0,0), second at (0,1), strobe 181 at (1,0), last at (239,179).
  - Each bit equals the pixel >= 128; start rises exactly 2 edges after the final accept; framesLoaded = 0 until handoff.
- Threshold boundary: binThreshold = 50 with pixels 49, 50, 51, 0, 255 → binaryDataOut 0, 1, 1, 0, 1.
- Backpressure and drop:
  - pixelValid random at 30% duty → same address sequence and data as the continuous case.
  - Non-SOF beats sent in IDLE before the frame → no strobes.
- Mid-frame SOF at beat 1000 → one-cycle frameError pulse; the next strobe is at (0,0); start rises only after a further 43200 beats.
- Handoff: in BUSY, pixelValid = 1 gives pixelReady = 0 and no strobes. Assert fullImageDone for 1 cycle → start = 0 on that edge, framesLoaded = 1, and a second frame then loads normally.
- Reset at beat 20000 → all outputs 0 immediately; a new SOF frame then completes with start rising as in the continuous case.

Source files
------------

// File: rtl/binary_frame_loader.sv
// Writer side of the binary image memory: binarizes a raster pixel stream and writes
// it column-major (y fastest), then hands the frame to the median block via start.
module binary_frame_loader #(
  parameter int X_SIZE = 240,
  parameter int Y_SIZE = 180,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PIX_W-1:0]  pixelIn,
  input  logic              pixelValid,
  input  logic              pixelSof,
  output logic              pixelReady,
  input  logic [PIX_W-1:0]  binThreshold,
  output logic [ADDR_W-1:0] xAddressOut,
  output logic [ADDR_W-1:0] yAddressOut,
  output logic              binaryDataOut,
  output logic              binaryMemWriteEnable,
  output logic              start,
  input  logic              fullImageDone,
  output logic              frameError,
  output logic [15:0]       framesLoaded
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    BUSY  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] X_LAST = ADDR_W'(X_SIZE - 1);
  localparam logic [ADDR_W-1:0] Y_LAST = ADDR_W'(Y_SIZE - 1);

  state_t            state, stateNext;
  logic [ADDR_W-1:0] xCnt, yCnt, xCntNext, yCntNext;
  logic [ADDR_W-1:0] wrX, wrY;
  logic              accept, lastPixel, writeNow, errNow, doneNow;

  // Column-major raster step: y runs fastest, x advances when y wraps.
  function automatic logic [2*ADDR_W-1:0] advance(input logic [ADDR_W-1:0] x,
                                                  input logic [ADDR_W-1:0] y);
    if (y == Y_LAST) return {x + ADDR_W'(1), {ADDR_W{1'b0}}};
    else             return {x, y + ADDR_W'(1)};
  endfunction

  assign accept    = pixelValid & pixelReady;
  assign lastPixel = (xCnt == X_LAST) && (yCnt == Y_LAST);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no branch can infer a latch.
    stateNext = state;
    xCntNext  = xCnt;
    yCntNext  = yCnt;
    wrX       = xCnt;
    wrY       = yCnt;
    writeNow  = 1'b0;
    errNow    = 1'b0;
    doneNow   = 1'b0;
    case (state)
      IDLE: begin
        if (accept && pixelSof) begin
          writeNow               = 1'b1;
          wrX                    = '0;
          wrY                    = '0;
          {xCntNext, yCntNext}   = advance('0, '0);
          stateNext              = LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          writeNow = 1'b1;
          if (pixelSof) begin
            errNow               = 1'b1;
            wrX                  = '0;
            wrY                  = '0;
            {xCntNext, yCntNext} = advance('0, '0);
          end else if (lastPixel) begin
            xCntNext  = '0;
            yCntNext  = '0;
            stateNext = FLUSH;
          end else begin
            {xCntNext, yCntNext} = advance(xCnt, yCnt);
          end
        end
      end
      FLUSH: stateNext = BUSY;
      BUSY: begin
        if (fullImageDone) begin
          doneNow   = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                <= IDLE;
      xCnt                 <= '0;
      yCnt                 <= '0;
      pixelReady           <= 1'b0;
      xAddressOut          <= '0;
      yAddressOut          <= '0;
      binaryDataOut        <= 1'b0;
      binaryMemWriteEnable <= 1'b0;
      start                <= 1'b0;
      frameError           <= 1'b0;
      framesLoaded         <= '0;
    end else begin
      state                <= stateNext;
      xCnt                 <= xCntNext;
      yCnt                 <= yCntNext;
      pixelReady           <= (stateNext == IDLE) || (stateNext == LOAD);
      binaryMemWriteEnable <= writeNow;
      start                <= (stateNext == BUSY);
      frameError           <= errNow;
      if (writeNow) begin
        xAddressOut   <= wrX;
        yAddressOut   <= wrY;
        binaryDataOut <= (pixelIn >= binThreshold);
      end
      if (doneNow) framesLoaded <= framesLoaded + 16'd1;
    end
  end

endmodule

// File: tb/tb_binary_frame_loader.sv
// Self-checking bench for binary_frame_loader: random raster streams compared against
// a linear-index frame model, plus threshold, handoff and reset scenarios.
module tb_binary_frame_loader;

  localparam int XS = 20;
  localparam int YS = 12;
  localparam int N  = XS * YS;
  localparam int AW = 5;
  localparam int PW = 8;
  localparam int OW = 1 + 1 + 1 + 16 + AW + AW + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [PW-1:0] pixelIn;
  logic          pixelValid;
  logic          pixelSof;
  logic          pixelReady;
  logic [PW-1:0] binThreshold;
  logic [AW-1:0] xAddressOut;
  logic [AW-1:0] yAddressOut;
  logic          binaryDataOut;
  logic          binaryMemWriteEnable;
  logic          start;
  logic          fullImageDone;
  logic          frameError;
  logic [15:0]   framesLoaded;

  int nTests = 0;
  int nFail  = 0;

  // Reference model: frame position as a linear pixel index.
  bit mInFrame = 1'b0;
  int mIdx     = 0;
  int mFrames  = 0;

  binary_frame_loader #(
    .X_SIZE(XS), .Y_SIZE(YS), .PIX_W(PW), .ADDR_W(AW)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .pixelIn             (pixelIn),
    .pixelValid          (pixelValid),
    .pixelSof            (pixelSof),
    .pixelReady          (pixelReady),
    .binThreshold        (binThreshold),
    .xAddressOut         (xAddressOut),
    .yAddressOut         (yAddressOut),
    .binaryDataOut       (binaryDataOut),
    .binaryMemWriteEnable(binaryMemWriteEnable),
    .start               (start),
    .fullImageDone       (fullImageDone),
    .frameError          (frameError),
    .framesLoaded        (framesLoaded)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic s, input logic [PW-1:0] p,
                       input logic [PW-1:0] th, input logic done, output bit acc);
    @(negedge clk);
    pixelValid    = v;
    pixelSof      = s;
    pixelIn       = p;
    binThreshold  = th;
    fullImageDone = done;
    acc = v && (pixelReady === 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic model_beat(input bit sof, input logic [PW-1:0] p, input logic [PW-1:0] th,
                            output bit we, output int x, output int y, output bit d,
                            output bit err, output bit last);
    we = 0; x = 0; y = 0; d = 0; err = 0; last = 0;
    if (sof) begin
      err      = mInFrame;
      mInFrame = 1'b1;
      mIdx     = 0;
    end
    if (mInFrame) begin
      we = 1;
      x  = mIdx / YS;
      y  = mIdx % YS;
      d  = (int'(p) >= int'(th));
      mIdx++;
      if (mIdx == N) begin
        mInFrame = 1'b0;
        last     = 1;
      end
    end
  endtask

  function automatic logic [OW-1:0] observe(input bit showAddr);
    return {binaryMemWriteEnable, frameError, start, framesLoaded,
            showAddr ? xAddressOut : AW'(0), showAddr ? yAddressOut : AW'(0),
            showAddr ? binaryDataOut : 1'b0};
  endfunction

  task automatic test_reset();
    #3;
    nTests++;
    if ({pixelReady, xAddressOut, yAddressOut, binaryDataOut, binaryMemWriteEnable,
         start, frameError, framesLoaded} !== '0) begin
      nFail++;
      $display("FAIL reset_values: got rdy=%b x=%0d y=%0d d=%b we=%b start=%b err=%b frames=%0d, expected all 0",
               pixelReady, xAddressOut, yAddressOut, binaryDataOut, binaryMemWriteEnable,
               start, frameError, framesLoaded);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    nTests++;
    if (pixelReady !== 1'b0) begin
      nFail++;
      $display("FAIL ready_before_edge: got %b, expected 0", pixelReady);
    end
    @(posedge clk);
    #1;
    nTests++;
    if (pixelReady !== 1'b1) begin
      nFail++;
      $display("FAIL ready_first_edge: got %b, expected 1", pixelReady);
    end
  endtask

  task automatic test_idle_drop();
    bit acc, we, d, err, last;
    int x, y;
    logic [PW-1:0] p;
    for (int i = 0; i < 8; i++) begin
      p = PW'($urandom_range(255));
      drive(1'b1, 1'b0, p, 8'd128, 1'($urandom_range(1)), acc);
      model_beat(1'b0, p, 8'd128, we, x, y, d, err, last);
      nTests++;
      if ({acc, binaryMemWriteEnable, frameError, start} !== {1'b1, we, err, 1'b0}) begin
        nFail++;
        $display("FAIL idle_drop beat %0d: got acc=%b we=%b err=%b start=%b, expected acc=1 we=%b err=%b start=0",
                 i, acc, binaryMemWriteEnable, frameError, start, we, err);
      end
    end
  endtask

  task automatic test_threshold();
    logic [PW-1:0] pix [5] = '{8'd49, 8'd50, 8'd51, 8'd0, 8'd255};
    bit            bits[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    bit acc, we, d, err, last;
    int x, y;
    logic [PW-1:0] p;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, i == 0, pix[i], 8'd50, 1'b0, acc);
      model_beat(i == 0, pix[i], 8'd50, we, x, y, d, err, last);
      nTests++;
      if ({binaryMemWriteEnable, frameError, xAddressOut, yAddressOut, binaryDataOut} !==
          {1'b1, 1'b0, AW'(0), AW'(i), bits[i]}) begin
        nFail++;
        $display("FAIL threshold pix=%0d: got we=%b err=%b x=%0d y=%0d d=%b, expected we=1 err=0 x=0 y=%0d d=%b",
                 pix[i], binaryMemWriteEnable, frameError, xAddressOut, yAddressOut,
                 binaryDataOut, i, bits[i]);
      end
    end
    // Carry the frame on well past the first column so the reset test interrupts real state.
    for (int i = 5; i < 150; i++) begin
      p = PW'($urandom_range(255));
      drive(1'b1, 1'b0, p, 8'd128, 1'b0, acc);
      model_beat(1'b0, p, 8'd128, we, x, y, d, err, last);
      nTests++;
      if (observe(1'b1) !== {we, err, 1'b0, 16'(mFrames), AW'(x), AW'(y), d}) begin
        nFail++;
        $display("FAIL partial_frame beat %0d: got %h expected %h", i, observe(1'b1),
                 {we, err, 1'b0, 16'(mFrames), AW'(x), AW'(y), d});
      end
    end
  endtask

  task automatic test_reset_midframe();
    bit acc;
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    nTests++;
    if ({pixelReady, xAddressOut, yAddressOut, binaryDataOut, binaryMemWriteEnable,
         start, frameError, framesLoaded} !== '0) begin
      nFail++;
      $display("FAIL reset_midframe: got rdy=%b x=%0d y=%0d d=%b we=%b start=%b frames=%0d, expected all 0",
               pixelReady, xAddressOut, yAddressOut, binaryDataOut, binaryMemWriteEnable,
               start, framesLoaded);
    end
    mInFrame = 1'b0;
    mIdx     = 0;
    mFrames  = 0;
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b0, 8'd0, 8'd128, 1'b0, acc);
    nTests++;
    if (pixelReady !== 1'b1) begin
      nFail++;
      $display("FAIL ready_after_reset: got %b, expected 1", pixelReady);
    end
  endtask

  task automatic stream_frame(input int duty, input int sofAgainAt, input bit randThr,
                              output int strobes);
    int b, cyc;
    bit acc, v, s, done, we, d, err, last;
    int x, y;
    logic [PW-1:0] p, th;
    logic [OW-1:0] expv, obs;
    b = 0; cyc = 0; done = 0; strobes = 0;
    while (!done && cyc < 40 * N) begin
      v  = ($urandom_range(99) < duty);
      s  = v && (b == 0 || b == sofAgainAt);
      p  = PW'($urandom_range(255));
      th = randThr ? PW'($urandom_range(255)) : PW'(128);
      drive(v, s, p, th, 1'($urandom_range(1)), acc);
      cyc++;
      we = 0; x = 0; y = 0; d = 0; err = 0; last = 0;
      if (acc) begin
        model_beat(s, p, th, we, x, y, d, err, last);
        b++;
      end
      expv = {we, err, 1'b0, 16'(mFrames), AW'(x), AW'(y), d};
      obs  = observe(we);
      nTests++;
      if (obs !== expv) begin
        nFail++;
        $display("FAIL stream beat %0d cycle %0d: got {we,err,start,frames,x,y,d}=%h expected %h",
                 b, cyc, obs, expv);
      end
      if (binaryMemWriteEnable === 1'b1) strobes++;
      if (last) done = 1;
    end
    nTests++;
    if (!done) begin
      nFail++;
      $display("FAIL stream_timeout: got %0d beats in %0d cycles, expected frame end", b, cyc);
    end else if (pixelReady !== 1'b0) begin
      nFail++;
      $display("FAIL ready_drop_at_last: got %b, expected 0", pixelReady);
    end
    drive(1'b1, 1'b0, PW'($urandom_range(255)), 8'd128, 1'b0, acc);
    nTests++;
    if ({acc, binaryMemWriteEnable, start, pixelReady, framesLoaded} !==
        {1'b0, 1'b0, 1'b1, 1'b0, 16'(mFrames)}) begin
      nFail++;
      $display("FAIL start_rise: got acc=%b we=%b start=%b rdy=%b frames=%0d, expected acc=0 we=0 start=1 rdy=0 frames=%0d",
               acc, binaryMemWriteEnable, start, pixelReady, framesLoaded, mFrames);
    end
  endtask

  task automatic test_continuous();
    int strobes;
    stream_frame(100, -1, 1'b0, strobes);
    nTests++;
    if (strobes !== N) begin
      nFail++;
      $display("FAIL continuous_strobes: got %0d, expected %0d", strobes, N);
    end
  endtask

  task automatic test_backpressure();
    int strobes;
    stream_frame(30, -1, 1'b1, strobes);
    nTests++;
    if (strobes !== N) begin
      nFail++;
      $display("FAIL backpressure_strobes: got %0d, expected %0d", strobes, N);
    end
  endtask

  task automatic test_midframe_sof();
    int strobes;
    stream_frame(100, 100, 1'b0, strobes);
    nTests++;
    if (strobes !== 100 + N) begin
      nFail++;
      $display("FAIL midframe_strobes: got %0d, expected %0d", strobes, 100 + N);
    end
  endtask

  task automatic test_handoff();
    bit acc;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'($urandom_range(1)), PW'($urandom_range(255)), 8'd128, 1'b0, acc);
      nTests++;
      if ({acc, binaryMemWriteEnable, start, pixelReady} !== 4'b0010) begin
        nFail++;
        $display("FAIL busy_hold %0d: got acc=%b we=%b start=%b rdy=%b, expected 0 0 1 0",
                 i, acc, binaryMemWriteEnable, start, pixelReady);
      end
    end
    drive(1'b0, 1'b0, 8'd0, 8'd128, 1'b1, acc);
    mFrames++;
    nTests++;
    if ({start, pixelReady, binaryMemWriteEnable, framesLoaded} !==
        {1'b0, 1'b1, 1'b0, 16'(mFrames)}) begin
      nFail++;
      $display("FAIL handoff: got start=%b rdy=%b we=%b frames=%0d, expected start=0 rdy=1 we=0 frames=%0d",
               start, pixelReady, binaryMemWriteEnable, framesLoaded, mFrames);
    end
    drive(1'b0, 1'b0, 8'd0, 8'd128, 1'b0, acc);
  endtask

  task automatic test_reset_busy();
    nTests++;
    if ({start, framesLoaded} !== {1'b1, 16'(mFrames)}) begin
      nFail++;
      $display("FAIL busy_before_reset: got start=%b frames=%0d, expected start=1 frames=%0d",
               start, framesLoaded, mFrames);
    end
    test_reset_midframe();
  endtask

  initial begin
    reset         = 1'b1;
    pixelIn       = '0;
    pixelValid    = 1'b0;
    pixelSof      = 1'b0;
    binThreshold  = '0;
    fullImageDone = 1'b0;
    test_reset();
    test_idle_drop();
    test_threshold();
    test_reset_midframe();
    test_continuous();
    test_handoff();
    test_backpressure();
    test_handoff();
    test_midframe_sof();
    test_reset_busy();
    test_continuous();
    test_handoff();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of run, expected summary before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
